// File: rtl/bench_chk_pkg.sv
// Shared definitions for the benchmark response checker: FSM states, default
// MISR constants and the 16-bit MISR step used by generators and reference models.
package bench_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] MISR_POLY = 16'h002D;  // x^16+x^5+x^3+x^2+1
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] data);
        misr_next = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
    endfunction

endpackage

// File: rtl/bench_resp_misr_if.sv
// Valid/ready response bus from the benchmark circuit into the compactor.
interface bench_resp_misr_if #(
    parameter int OUT_W = 13
);
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bench_misr_core.sv
// Registered multiple-input signature register with seed load and step enable.
// sig_step is the value the register takes on an enabled step, exposed for look-ahead compares.
module bench_misr_core
    import bench_chk_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(MISR_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_step
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ data;
        sig_d    = sig_q;
        // A seed load takes priority so a restart never folds in a stray vector.
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = sig_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bench_resp_misr.sv
// Response compactor: folds NUM_VEC benchmark output vectors into a MISR and
// compares the final signature against a golden value.
module bench_resp_misr
    import bench_chk_pkg::*;
#(
    parameter int               OUT_W   = 13,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(MISR_POLY),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(MISR_SEED),
    parameter int               NUM_VEC = 2048,
    parameter int               CNT_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    bench_resp_misr_if.slave     in_if,
    input  logic [SIG_W-1:0]     golden,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_W-1:0]     signature,
    output logic [CNT_W-1:0]     vec_count
);

    if (SIG_W < OUT_W) begin : g_bad_sig_w
        $error("bench_resp_misr: SIG_W must be >= OUT_W");
    end
    if (NUM_VEC < 1 || NUM_VEC >= (2 ** CNT_W)) begin : g_bad_num_vec
        $error("bench_resp_misr: NUM_VEC must be in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC - 1);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             misr_load;
    logic             misr_en;
    logic             xfer;
    logic [OUT_W-1:0] in_data_w;
    logic [SIG_W-1:0] inject;
    logic [SIG_W-1:0] sig_cur;
    logic [SIG_W-1:0] sig_step;

    assign in_data_w = in_if.in_data;
    assign inject    = SIG_W'(in_data_w);
    assign xfer      = in_if.in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        in_ready_d = in_ready_q;
        cnt_d      = cnt_q;
        misr_load  = 1'b0;
        misr_en    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    in_ready_d = 1'b1;
                    cnt_d      = '0;
                    misr_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    misr_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    // Final vector: judge the look-ahead signature so pass lines up with done.
                    if (cnt_q == LAST_CNT) begin
                        state_d    = ST_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        in_ready_d = 1'b0;
                        pass_d     = (sig_step == golden);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                pass_d     = 1'b0;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    bench_misr_core #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (misr_load),
        .en       (misr_en),
        .data     (inject),
        .sig      (sig_cur),
        .sig_step (sig_step)
    );

    assign in_if.in_ready = in_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign signature      = sig_cur;
    assign vec_count      = cnt_q;

endmodule

// File: tb/tb_bench_resp_misr.sv
// Directed bench for bench_resp_misr: four instances cover NUM_VEC=2048/1/2/4
// and the SEED=0 case, checked against hand-computed signatures and a local model.
module tb_bench_resp_misr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Instance A: default parameters
    logic        st_a = 1'b0;
    logic [15:0] gd_a = '0;
    logic        busy_a, done_a, pass_a;
    logic [15:0] sig_a;
    logic [11:0] cnt_a;
    bench_resp_misr_if #(.OUT_W(13)) if_a ();

    // Instance B: NUM_VEC=1
    logic        st_b = 1'b0;
    logic [15:0] gd_b = '0;
    logic        busy_b, done_b, pass_b;
    logic [15:0] sig_b;
    logic [11:0] cnt_b;
    bench_resp_misr_if #(.OUT_W(13)) if_b ();

    // Instance C: NUM_VEC=2, SEED=0
    logic        st_c = 1'b0;
    logic [15:0] gd_c = '0;
    logic        busy_c, done_c, pass_c;
    logic [15:0] sig_c;
    logic [11:0] cnt_c;
    bench_resp_misr_if #(.OUT_W(13)) if_c ();

    // Instance D: NUM_VEC=4
    logic        st_d = 1'b0;
    logic [15:0] gd_d = '0;
    logic        busy_d, done_d, pass_d;
    logic [15:0] sig_d;
    logic [11:0] cnt_d;
    bench_resp_misr_if #(.OUT_W(13)) if_d ();

    bench_resp_misr dut_a (
        .clk(clk), .rst(rst), .start(st_a), .in_if(if_a.slave), .golden(gd_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .vec_count(cnt_a)
    );
    bench_resp_misr #(.NUM_VEC(1)) dut_b (
        .clk(clk), .rst(rst), .start(st_b), .in_if(if_b.slave), .golden(gd_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .vec_count(cnt_b)
    );
    bench_resp_misr #(.NUM_VEC(2), .SEED(16'h0000)) dut_c (
        .clk(clk), .rst(rst), .start(st_c), .in_if(if_c.slave), .golden(gd_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .vec_count(cnt_c)
    );
    bench_resp_misr #(.NUM_VEC(4)) dut_d (
        .clk(clk), .rst(rst), .start(st_d), .in_if(if_d.slave), .golden(gd_d),
        .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d), .vec_count(cnt_d)
    );

    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [12:0] d);
        logic [15:0] fb;
        fb       = s[15] ? 16'h002D : 16'h0000;
        ref_step = {s[14:0], 1'b0} ^ fb ^ {3'b000, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [12:0] rvec [2048];
    logic [15:0] model;
    logic [12:0] dvec [4];
    logic        dpat [7];
    int          k;

    initial begin
        if_a.in_valid = 1'b0; if_a.in_data = '0;
        if_b.in_valid = 1'b0; if_b.in_data = '0;
        if_c.in_valid = 1'b0; if_c.in_data = '0;
        if_d.in_valid = 1'b0; if_d.in_data = '0;

        // Reset state
        tick(); tick();
        chk16("rst_sig", sig_a, 16'h0000);
        chkc ("rst_cnt", cnt_a, 12'd0);
        chk1 ("rst_ready", if_a.in_ready, 1'b0);
        chk1 ("rst_busy", busy_a, 1'b0);
        chk1 ("rst_done", done_a, 1'b0);
        chk1 ("rst_pass", pass_a, 1'b0);
        rst = 1'b0;
        tick();
        chk1 ("idle_ready", if_a.in_ready, 1'b0);
        $display("reset: sig=%h cnt=%0d ready=%b", sig_a, cnt_a, if_a.in_ready);

        // Start on A, three transfers, then reset mid-run
        st_a = 1'b1; tick(); st_a = 1'b0;
        chk1 ("a_start_busy", busy_a, 1'b1);
        chk1 ("a_start_ready", if_a.in_ready, 1'b1);
        chk16("a_start_seed", sig_a, 16'hFFFF);
        if_a.in_valid = 1'b1; if_a.in_data = 13'h0000;
        tick();
        chk16("a_first_step", sig_a, 16'hFFD3);
        tick(); tick();
        chkc ("a_three_xfers", cnt_a, 12'd3);
        if_a.in_valid = 1'b0;
        rst = 1'b1; tick();
        chk16("midrst_sig", sig_a, 16'h0000);
        chkc ("midrst_cnt", cnt_a, 12'd0);
        chk1 ("midrst_busy", busy_a, 1'b0);
        chk1 ("midrst_ready", if_a.in_ready, 1'b0);
        st_a = 1'b1; tick(); st_a = 1'b0;
        chk1 ("rst_beats_start", busy_a, 1'b0);
        rst = 1'b0;
        $display("mid-run reset: sig=%h cnt=%0d busy=%b", sig_a, cnt_a, busy_a);

        // B: NUM_VEC=1, SEED=FFFF, single zero vector
        st_b = 1'b1; tick(); st_b = 1'b0;
        if_b.in_valid = 1'b1; if_b.in_data = 13'h0000;
        tick();
        chk16("b_sig", sig_b, 16'hFFD3);
        chk1 ("b_done", done_b, 1'b1);
        chkc ("b_cnt", cnt_b, 12'd1);
        chk1 ("b_ready", if_b.in_ready, 1'b0);
        tick();
        chkc ("b_no_extra", cnt_b, 12'd1);
        chk16("b_sig_hold", sig_b, 16'hFFD3);
        if_b.in_valid = 1'b0;
        $display("nv1: sig=%h done=%b cnt=%0d", sig_b, done_b, cnt_b);

        // C: NUM_VEC=2, SEED=0, vectors 1FFF then 0000
        gd_c = 16'h3FFE;
        st_c = 1'b1; tick(); st_c = 1'b0;
        chk16("c_seed", sig_c, 16'h0000);
        if_c.in_valid = 1'b1; if_c.in_data = 13'h1FFF;
        tick();
        chk16("c_sig1", sig_c, 16'h1FFF);
        chk1 ("c_not_done", done_c, 1'b0);
        if_c.in_data = 13'h0000;
        tick();
        if_c.in_valid = 1'b0;
        chk16("c_sig2", sig_c, 16'h3FFE);
        chk1 ("c_done", done_c, 1'b1);
        chk1 ("c_pass", pass_c, 1'b1);
        $display("nv2 golden=3FFE: sig=%h pass=%b", sig_c, pass_c);
        gd_c = 16'h3FFF;
        st_c = 1'b1; tick(); st_c = 1'b0;
        chk1 ("c_restart_pass", pass_c, 1'b0);
        chk1 ("c_restart_done", done_c, 1'b0);
        if_c.in_valid = 1'b1; if_c.in_data = 13'h1FFF;
        tick();
        if_c.in_data = 13'h0000;
        tick();
        if_c.in_valid = 1'b0;
        chk16("c_bad_sig", sig_c, 16'h3FFE);
        chk1 ("c_bad_done", done_c, 1'b1);
        chk1 ("c_bad_pass", pass_c, 1'b0);
        $display("nv2 golden=3FFF: sig=%h pass=%b", sig_c, pass_c);

        // D: NUM_VEC=4 with gaps; gap-free signature of 1,2,4,8 from FFFF is FE5B
        dvec[0] = 13'h0001; dvec[1] = 13'h0002; dvec[2] = 13'h0004; dvec[3] = 13'h0008;
        dpat[0] = 1'b1; dpat[1] = 1'b0; dpat[2] = 1'b0; dpat[3] = 1'b1;
        dpat[4] = 1'b1; dpat[5] = 1'b0; dpat[6] = 1'b1;
        st_d = 1'b1; tick(); st_d = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if_d.in_valid = dpat[i];
            if_d.in_data  = dvec[k];
            st_d = (i == 2);
            tick();
            if (dpat[i]) k++;
            if (i == 2) begin
                chkc ("d_start_ignored_cnt", cnt_d, 12'd1);
                chk16("d_start_ignored_sig", sig_d, 16'hFFD2);
            end
        end
        st_d = 1'b0; if_d.in_valid = 1'b0;
        chk16("d_sig", sig_d, 16'hFE5B);
        chkc ("d_cnt", cnt_d, 12'd4);
        chk1 ("d_done", done_d, 1'b1);
        $display("gaps: sig=%h cnt=%0d done=%b", sig_d, cnt_d, done_d);

        // A: full default run against the local model
        model = 16'hFFFF;
        for (int j = 0; j < 2048; j++) begin
            rvec[j] = 13'($urandom);
            model   = ref_step(model, rvec[j]);
        end
        gd_a = model;
        st_a = 1'b1; tick(); st_a = 1'b0;
        for (int j = 0; j < 2048; j++) begin
            if_a.in_valid = 1'b1;
            if_a.in_data  = rvec[j];
            tick();
            if (j == 2046) chk1("a_done_early", done_a, 1'b0);
        end
        chk16("a_sig", sig_a, model);
        chk1 ("a_done", done_a, 1'b1);
        chk1 ("a_pass", pass_a, 1'b1);
        chkc ("a_cnt", cnt_a, 12'h800);
        chk1 ("a_busy_low", busy_a, 1'b0);
        if_a.in_data = 13'h1ABC;
        tick();
        if_a.in_valid = 1'b0;
        chk1 ("a_2049_ready", if_a.in_ready, 1'b0);
        chkc ("a_2049_cnt", cnt_a, 12'h800);
        chk16("a_2049_sig", sig_a, model);
        $display("full run: sig=%h model=%h pass=%b cnt=%0d", sig_a, model, pass_a, cnt_a);

        // Restart from DONE
        st_a = 1'b1; tick(); st_a = 1'b0;
        chk1 ("restart_busy", busy_a, 1'b1);
        chk1 ("restart_done", done_a, 1'b0);
        chk1 ("restart_pass", pass_a, 1'b0);
        chkc ("restart_cnt", cnt_a, 12'd0);
        chk16("restart_sig", sig_a, 16'hFFFF);
        $display("restart: busy=%b done=%b sig=%h cnt=%0d", busy_a, done_a, sig_a, cnt_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
